pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use detection, global stall gating, exception
// capture across long stalls, and saturating stall performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned NUM_SLOTS     = 2,
    parameter int unsigned REG_AW        = 5,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned FIFO_DECOUPLE = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        i_stall,
    input  logic                        d_stall,
    input  logic                        div_stall,
    input  logic [NUM_SLOTS-1:0]        D_valid,
    input  logic [NUM_SLOTS*REG_AW-1:0] D_rs,
    input  logic [NUM_SLOTS*REG_AW-1:0] D_rt,
    input  logic [NUM_SLOTS-1:0]        E_memtoReg,
    input  logic [NUM_SLOTS-1:0]        M_memtoReg,
    input  logic [NUM_SLOTS*REG_AW-1:0] E_waddr,
    input  logic [NUM_SLOTS*REG_AW-1:0] M_waddr,
    input  logic                        E_branch_taken,
    input  logic                        M_except,
    input  logic                        cnt_clr,
    output logic                        longest_stall,
    output logic [4:0]                  stage_ena,
    output logic [4:0]                  stage_flush,
    output logic                        exc_fire,
    output logic                        exc_pending,
    output logic [CNT_W-1:0]            lw_stall_cnt,
    output logic [CNT_W-1:0]            long_stall_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;

    logic lwstall;
    logic de_ena;
    logic f_ena;
    logic de_flush;
    logic fifo_pass;

    // A hit needs a nonzero load destination; equality then implies a nonzero source.
    always_comb begin
        lwstall = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
                if (D_valid[i]) begin
                    if (E_memtoReg[j] && (E_waddr[j*REG_AW +: REG_AW] != '0) &&
                        ((D_rs[i*REG_AW +: REG_AW] == E_waddr[j*REG_AW +: REG_AW]) ||
                         (D_rt[i*REG_AW +: REG_AW] == E_waddr[j*REG_AW +: REG_AW]))) begin
                        lwstall = 1'b1;
                    end
                    if (M_memtoReg[j] && (M_waddr[j*REG_AW +: REG_AW] != '0) &&
                        ((D_rs[i*REG_AW +: REG_AW] == M_waddr[j*REG_AW +: REG_AW]) ||
                         (D_rt[i*REG_AW +: REG_AW] == M_waddr[j*REG_AW +: REG_AW]))) begin
                        lwstall = 1'b1;
                    end
                end
            end
        end
    end

    assign longest_stall = i_stall | d_stall | div_stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (M_except && longest_stall) state <= HOLD;
                HOLD:    if (!longest_stall) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign exc_pending = (state == HOLD);
    assign exc_fire    = ~longest_stall & (((state == RUN) & M_except) | (state == HOLD));

    // Fetch may keep filling its queue while only the data side is stalled.
    assign fifo_pass = (FIFO_DECOUPLE != 0) & d_stall & ~i_stall & ~div_stall & ~lwstall;
    assign de_ena    = ~(lwstall | longest_stall);
    assign f_ena     = de_ena | fifo_pass;
    assign stage_ena = {~longest_stall, ~longest_stall, ~longest_stall, de_ena, f_ena};

    assign de_flush    = exc_fire | (E_branch_taken & ~longest_stall & ~exc_pending);
    assign stage_flush = {1'b0, exc_fire, de_flush, de_flush, 1'b0};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lw_stall_cnt <= '0;
        end else if (cnt_clr) begin
            lw_stall_cnt <= '0;
        end else if (lwstall && !longest_stall && (lw_stall_cnt != '1)) begin
            lw_stall_cnt <= lw_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            long_stall_cnt <= '0;
        end else if (cnt_clr) begin
            long_stall_cnt <= '0;
        end else if (longest_stall && (long_stall_cnt != '1)) begin
            long_stall_cnt <= long_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a behavioural model;
// a second instance covers FIFO_DECOUPLE = 0 and 4-bit counter saturation.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        resetn;
    logic        i_stall, d_stall, div_stall;
    logic [1:0]  D_valid;
    logic [9:0]  D_rs, D_rt;
    logic [1:0]  E_memtoReg, M_memtoReg;
    logic [9:0]  E_waddr, M_waddr;
    logic        E_branch_taken, M_except, cnt_clr;

    logic        longest_stall, exc_fire, exc_pending;
    logic [4:0]  stage_ena, stage_flush;
    logic [31:0] lw_stall_cnt, long_stall_cnt;

    logic        nd_longest_stall, nd_exc_fire, nd_exc_pending;
    logic [4:0]  nd_stage_ena, nd_stage_flush;
    logic [3:0]  nd_lw_stall_cnt, nd_long_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: a captured exception flag and plain integer counters.
    bit     m_captured;
    longint m_lw, m_long, m_lw4, m_long4;

    pipe_hazard_ctrl dut (
        .clk(clk), .resetn(resetn), .i_stall(i_stall), .d_stall(d_stall),
        .div_stall(div_stall), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
        .E_memtoReg(E_memtoReg), .M_memtoReg(M_memtoReg), .E_waddr(E_waddr),
        .M_waddr(M_waddr), .E_branch_taken(E_branch_taken), .M_except(M_except),
        .cnt_clr(cnt_clr), .longest_stall(longest_stall), .stage_ena(stage_ena),
        .stage_flush(stage_flush), .exc_fire(exc_fire), .exc_pending(exc_pending),
        .lw_stall_cnt(lw_stall_cnt), .long_stall_cnt(long_stall_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4), .FIFO_DECOUPLE(0)) dut_nd (
        .clk(clk), .resetn(resetn), .i_stall(i_stall), .d_stall(d_stall),
        .div_stall(div_stall), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
        .E_memtoReg(E_memtoReg), .M_memtoReg(M_memtoReg), .E_waddr(E_waddr),
        .M_waddr(M_waddr), .E_branch_taken(E_branch_taken), .M_except(M_except),
        .cnt_clr(cnt_clr), .longest_stall(nd_longest_stall), .stage_ena(nd_stage_ena),
        .stage_flush(nd_stage_flush), .exc_fire(nd_exc_fire), .exc_pending(nd_exc_pending),
        .lw_stall_cnt(nd_lw_stall_cnt), .long_stall_cnt(nd_long_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_lwstall();
        int loads[$];
        int rs, rt;
        for (int j = 0; j < 2; j++) begin
            if (E_memtoReg[j] && E_waddr[j*5 +: 5] != 5'd0) loads.push_back(int'(E_waddr[j*5 +: 5]));
            if (M_memtoReg[j] && M_waddr[j*5 +: 5] != 5'd0) loads.push_back(int'(M_waddr[j*5 +: 5]));
        end
        for (int i = 0; i < 2; i++) begin
            if (D_valid[i]) begin
                rs = int'(D_rs[i*5 +: 5]);
                rt = int'(D_rt[i*5 +: 5]);
                foreach (loads[k]) if (rs == loads[k] || rt == loads[k]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic longint sat_inc(input longint v, input longint maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic model_reset();
        m_captured = 1'b0;
        m_lw = 0; m_long = 0; m_lw4 = 0; m_long4 = 0;
    endtask

    task automatic clear_inputs();
        i_stall = 0; d_stall = 0; div_stall = 0;
        D_valid = '0; D_rs = '0; D_rt = '0;
        E_memtoReg = '0; M_memtoReg = '0; E_waddr = '0; M_waddr = '0;
        E_branch_taken = 0; M_except = 0; cnt_clr = 0;
    endtask

    // Called just after a rising edge with inputs already driven; checks at the
    // falling edge, then advances the model across the next rising edge.
    task automatic step(input string tag, input int want_ena = -1, input int want_flush = -1,
                        input int want_pend = -1, input int want_fire = -1,
                        input int want_ena_nd = -1);
        bit ls, lw, fire, dfl;
        logic [4:0] ena, ena_nd, fl;
        @(negedge clk);
        ls   = i_stall | d_stall | div_stall;
        lw   = exp_lwstall();
        fire = !ls && (M_except || m_captured);
        dfl  = fire || (E_branch_taken && !ls && !m_captured);
        fl   = {1'b0, fire, dfl, dfl, 1'b0};
        if (ls)      ena = 5'b00000;
        else if (lw) ena = 5'b11100;
        else         ena = 5'b11111;
        ena_nd = ena;
        if (d_stall && !i_stall && !div_stall && !lw) ena[0] = 1'b1;

        check({tag, ".lstall"}, 64'(longest_stall), 64'(ls));
        check({tag, ".ena"}, 64'(stage_ena), 64'(ena));
        check({tag, ".flush"}, 64'(stage_flush), 64'(fl));
        check({tag, ".fire"}, 64'(exc_fire), 64'(fire));
        check({tag, ".pend"}, 64'(exc_pending), 64'(m_captured));
        check({tag, ".lwcnt"}, 64'(lw_stall_cnt), 64'(m_lw));
        check({tag, ".longcnt"}, 64'(long_stall_cnt), 64'(m_long));
        check({tag, ".nd_ena"}, 64'(nd_stage_ena), 64'(ena_nd));
        check({tag, ".nd_flush"}, 64'(nd_stage_flush), 64'(fl));
        check({tag, ".nd_lwcnt"}, 64'(nd_lw_stall_cnt), 64'(m_lw4));
        check({tag, ".nd_longcnt"}, 64'(nd_long_stall_cnt), 64'(m_long4));
        if (want_ena >= 0)    check({tag, ".ena_k"}, 64'(stage_ena), 64'(want_ena));
        if (want_flush >= 0)  check({tag, ".flush_k"}, 64'(stage_flush), 64'(want_flush));
        if (want_pend >= 0)   check({tag, ".pend_k"}, 64'(exc_pending), 64'(want_pend));
        if (want_fire >= 0)   check({tag, ".fire_k"}, 64'(exc_fire), 64'(want_fire));
        if (want_ena_nd >= 0) check({tag, ".nd_ena_k"}, 64'(nd_stage_ena), 64'(want_ena_nd));

        @(posedge clk);
        if (resetn) begin
            if (!m_captured) m_captured = M_except && ls;
            else             m_captured = ls;
            if (cnt_clr) begin
                m_lw = 0; m_long = 0; m_lw4 = 0; m_long4 = 0;
            end else begin
                if (lw && !ls) begin
                    m_lw  = sat_inc(m_lw, 64'hFFFF_FFFF);
                    m_lw4 = sat_inc(m_lw4, 15);
                end
                if (ls) begin
                    m_long  = sat_inc(m_long, 64'hFFFF_FFFF);
                    m_long4 = sat_inc(m_long4, 15);
                end
            end
        end
        #1;
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;
        model_reset();
        #2;
        check("reset.pend", 64'(exc_pending), 64'd0);
        check("reset.cnt", 64'(long_stall_cnt), 64'd0);
        M_except = 1;
        step("rst_exc", -1, -1, 0, 1);
        clear_inputs();
        step("rst_idle", 5'b11111, 5'b00000, 0, 0);
        resetn = 1'b1;
        step("idle", 5'b11111, 5'b00000, 0, 0);

        // Load-use on the slave slot
        E_memtoReg = 2'b10; E_waddr = {5'd7, 5'd0}; D_rt = {5'd7, 5'd0}; D_valid = 2'b11;
        step("lw_slave", 5'b11100);
        check("lw_slave.cnt", 64'(lw_stall_cnt), 64'd1);

        // Same pattern on register 0
        E_waddr = '0; D_rt = '0; D_rs = '0;
        step("lw_r0", 5'b11111);
        check("lw_r0.cnt", 64'(lw_stall_cnt), 64'd1);

        // Exception raised during a 4-cycle divide
        clear_inputs();
        div_stall = 1; M_except = 1;
        step("div_c1", 5'b00000, 5'b00000, 0, 0);
        M_except = 0;
        for (int c = 2; c <= 4; c++) step("div_c234", -1, 5'b00000, 1, 0);
        div_stall = 0;
        step("div_c5", -1, 5'b01110, 1, 1);
        step("div_c6", -1, 5'b00000, 0, 0);

        // Data stall with and without fetch decoupling
        d_stall = 1;
        step("dstall", 5'b00001, -1, -1, -1, 5'b00000);
        clear_inputs();

        // Branch resolved under an instruction stall
        E_branch_taken = 1; i_stall = 1;
        step("br_stall", -1, 5'b00000);
        i_stall = 0;
        step("br_go", -1, 5'b00110);
        clear_inputs();

        // Counter saturation on the 4-bit instance
        div_stall = 1;
        for (int c = 0; c < 20; c++) step("sat");
        check("sat.nd_long", 64'(nd_long_stall_cnt), 64'd15);
        cnt_clr = 1;
        step("sat_clr");
        cnt_clr = 0;
        step("sat_after_clr");
        clear_inputs();
        step("post_sat");

        // Reset asserted while an exception is held discards it
        div_stall = 1; M_except = 1;
        step("hold_in");
        M_except = 0;
        step("hold", -1, -1, 1);
        resetn = 0;
        model_reset();
        step("hold_rst", -1, -1, 0, 0);
        resetn = 1;
        div_stall = 0;
        step("hold_release", -1, 5'b00000, 0, 0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            i_stall   = ($urandom_range(0, 5) == 0);
            d_stall   = ($urandom_range(0, 5) == 0);
            div_stall = ($urandom_range(0, 7) == 0);
            D_valid   = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                D_rs[k*5 +: 5]    = 5'($urandom_range(0, 3));
                D_rt[k*5 +: 5]    = 5'($urandom_range(0, 3));
                E_waddr[k*5 +: 5] = 5'($urandom_range(0, 3));
                M_waddr[k*5 +: 5] = 5'($urandom_range(0, 3));
            end
            E_memtoReg     = 2'($urandom);
            M_memtoReg     = 2'($urandom);
            E_branch_taken = ($urandom_range(0, 3) == 0);
            M_except       = ($urandom_range(0, 5) == 0);
            cnt_clr        = ($urandom_range(0, 29) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
